// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if
// Bundles the requester, downstream and shared-line signals of the 2:1
// round-robin arbiter.
//   master : requester/downstream side (drives req_a, req_b, a_in, b_in,
//            out_ready; observes gnt_a, gnt_b, sel, y_out, y_valid)
//   slave  : arbiter side (the reverse)
interface mux_rr_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              req_a;
   logic              req_b;
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;
   logic              out_ready;
   logic              gnt_a;
   logic              gnt_b;
   logic              sel;
   logic [DATA_W-1:0] y_out;
   logic              y_valid;

   modport master (
      output req_a, req_b, a_in, b_in, out_ready,
      input  gnt_a, gnt_b, sel, y_out, y_valid
   );

   modport slave (
      input  req_a, req_b, a_in, b_in, out_ready,
      output gnt_a, gnt_b, sel, y_out, y_valid
   );
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter and sequencer for a shared 2:1 select datapath. Grants
// one of two requesters at a time, owns the mux select and registers the
// selected data onto the shared output for every accepted transfer.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of mux_rr_arbiter_if
//          req_a/req_b  requests, a_in/b_in data, out_ready downstream accept
//          gnt_a/gnt_b  grants (state decoded), sel (1=A, 0=B)
//          y_out/y_valid registered shared output
// Parameters:
//   DATA_W   : data width (must match the interface)
//   MAX_HOLD : consecutive transfers allowed while the other side waits (1..255)
module mux_rr_arbiter #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   mux_rr_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;
   typedef enum logic {SRV_A, SRV_B} srv_t;

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   state_t            state, state_nxt;
   srv_t              last_srv, last_srv_nxt;
   logic [7:0]        hold_cnt, hold_nxt;
   logic              sel_q, sel_nxt;
   logic [DATA_W-1:0] y_q;
   logic              y_vld_q;
   logic              xfer;
   logic              own_req;    // request of the current owner
   logic              other_req;  // request of the side waiting
   logic              hold_done;  // this transfer uses up the hold budget

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         last_srv <= SRV_B;
         hold_cnt <= 8'd0;
         sel_q    <= 1'b0;
         y_q      <= '0;
         y_vld_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         last_srv <= last_srv_nxt;
         hold_cnt <= hold_nxt;
         sel_q    <= sel_nxt;
         y_vld_q  <= xfer;
         if (xfer)
            y_q <= sel_q ? bus.a_in : bus.b_in;
      end
   end

   always_comb begin
      state_nxt    = state;
      last_srv_nxt = last_srv;
      hold_nxt     = hold_cnt;
      sel_nxt      = sel_q;
      xfer         = 1'b0;
      own_req      = 1'b0;
      other_req    = 1'b0;
      hold_done    = (hold_cnt + 8'd1) == HOLD_MAX;

      case (state)
         IDLE: begin
            if (bus.req_a && bus.req_b)
               state_nxt = (last_srv == SRV_A) ? GNT_B : GNT_A;
            else if (bus.req_a)
               state_nxt = GNT_A;
            else if (bus.req_b)
               state_nxt = GNT_B;
         end
         GNT_A, GNT_B: begin
            own_req   = (state == GNT_A) ? bus.req_a : bus.req_b;
            other_req = (state == GNT_A) ? bus.req_b : bus.req_a;
            if (!own_req) begin
               // Owner released: hand straight over or go idle, no transfer.
               if (other_req)
                  state_nxt = (state == GNT_A) ? GNT_B : GNT_A;
               else
                  state_nxt = IDLE;
            end else if (bus.out_ready) begin
               xfer = 1'b1;
               if (hold_done) begin
                  // Budget spent: yield if the other side waits, otherwise
                  // keep the grant and start a fresh budget.
                  hold_nxt = 8'd0;
                  if (other_req)
                     state_nxt = (state == GNT_A) ? GNT_B : GNT_A;
               end else begin
                  hold_nxt = hold_cnt + 8'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (state_nxt != state) begin
         hold_nxt = 8'd0;
         if (state_nxt == GNT_A) last_srv_nxt = SRV_A;
         if (state_nxt == GNT_B) last_srv_nxt = SRV_B;
      end

      // sel follows the owner and keeps its last value through IDLE.
      if (state_nxt == GNT_A) sel_nxt = 1'b1;
      else if (state_nxt == GNT_B) sel_nxt = 1'b0;
   end

   assign bus.gnt_a   = (state == GNT_A);
   assign bus.gnt_b   = (state == GNT_B);
   assign bus.sel     = sel_q;
   assign bus.y_out   = y_q;
   assign bus.y_valid = y_vld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
   localparam int DW = 8;
   localparam int MH = 4;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mux_rr_arbiter_if #(.DATA_W(DW)) bus();

   mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the line (0 none, 1 A, 2 B), how many
   // transfers it has made in this grant, and who was served last.
   int          own;
   int          cnt;
   int          last;
   logic        m_sel;
   logic [DW-1:0] m_y;
   logic        m_yv;

   task automatic model_reset();
      own = 0; cnt = 0; last = 2;
      m_sel = 1'b0; m_y = '0; m_yv = 1'b0;
   endtask

   task automatic model_step(input logic ra, input logic rb,
                             input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic rdy);
      int  new_own;
      int  new_cnt;
      logic mine, theirs;
      new_own = own;
      new_cnt = cnt;
      m_yv    = 1'b0;
      mine    = (own == 1) ? ra : rb;
      theirs  = (own == 1) ? rb : ra;
      if (own == 0) begin
         if (ra && rb)  new_own = (last == 1) ? 2 : 1;
         else if (ra)   new_own = 1;
         else if (rb)   new_own = 2;
      end else if (!mine) begin
         new_own = theirs ? 3 - own : 0;
      end else if (rdy) begin
         m_yv = 1'b1;
         m_y  = (own == 1) ? a : b;
         if (cnt + 1 == MH) begin
            new_cnt = 0;
            if (theirs) new_own = 3 - own;
         end else begin
            new_cnt = cnt + 1;
         end
      end
      if (new_own != own) begin
         cnt = 0;
         if (new_own != 0) last = new_own;
      end else begin
         cnt = new_cnt;
      end
      if (new_own == 1) m_sel = 1'b1;
      else if (new_own == 2) m_sel = 1'b0;
      own = new_own;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".gnt_a"},   DW'(bus.gnt_a),   DW'(own == 1));
      chk({tag, ".gnt_b"},   DW'(bus.gnt_b),   DW'(own == 2));
      chk({tag, ".sel"},     DW'(bus.sel),     DW'(m_sel));
      chk({tag, ".y_valid"}, DW'(bus.y_valid), DW'(m_yv));
      chk({tag, ".y_out"},   bus.y_out,        m_y);
   endtask

   // Drive inputs, advance one edge, then compare away from the edge.
   task automatic step(input string tag, input logic ra, input logic rb,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic rdy);
      bus.req_a = ra; bus.req_b = rb; bus.a_in = a; bus.b_in = b;
      bus.out_ready = rdy;
      model_step(ra, rb, a, b, rdy);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1;
      bus.req_a = 1'b0; bus.req_b = 1'b0; bus.a_in = '0; bus.b_in = '0;
      bus.out_ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      check_all("por");
      #3 rst = 1'b0;

      // Reset release then first A transfer.
      step("first_gnt", 1, 0, 8'h5A, 8'h00, 1);
      step("first_xfer", 1, 0, 8'h5A, 8'h00, 1);
      // Mid-transfer async reset: outputs clear without a clock edge.
      step("pre_rst", 1, 0, 8'h33, 8'h00, 1);
      do_reset();
      step("after_rst_a", 1, 0, 8'h5A, 8'h00, 1);
      step("after_rst_b", 1, 0, 8'h5A, 8'h00, 1);

      // Tie from IDLE: A first, alternate every MH transfers.
      do_reset();
      for (int i = 0; i < 12; i++)
         step("tie", 1, 1, 8'hA0 + 8'(i), 8'hB0 + 8'(i), 1);

      // Single requester B: keeps the grant across hold wraps.
      do_reset();
      for (int i = 0; i < 11; i++)
         step("single_b", 0, 1, 8'h00, 8'h10 + 8'(i), 1);

      // Stall in GNT_A, count intact afterwards (B joins to expose it).
      do_reset();
      step("stall_g", 1, 0, 8'h21, 8'h00, 1);
      step("stall_x1", 1, 0, 8'h22, 8'h00, 1);
      step("stall_x2", 1, 0, 8'h23, 8'h00, 1);
      for (int i = 0; i < 3; i++)
         step("stall_hold", 1, 1, 8'h24, 8'h99, 0);
      for (int i = 0; i < 4; i++)
         step("stall_resume", 1, 1, 8'h25 + 8'(i), 8'h99, 1);

      // Early release to B, then release to idle.
      do_reset();
      step("early_g", 1, 1, 8'h41, 8'h51, 1);
      step("early_x1", 1, 1, 8'h42, 8'h52, 1);
      step("early_x2", 1, 1, 8'h43, 8'h53, 1);
      step("early_drop", 0, 1, 8'h44, 8'h54, 1);
      step("early_b1", 0, 1, 8'h45, 8'h55, 1);
      step("early_b2", 1, 0, 8'h46, 8'h56, 1);
      step("early_a", 1, 0, 8'h47, 8'h57, 1);
      step("idle_drop", 0, 0, 8'h48, 8'h58, 1);
      step("idle_hold", 0, 0, 8'h49, 8'h59, 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++)
         step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
